// File: rtl/cmd_alu_pkg.sv
// cmd_alu_pkg: shared definitions for the byte-serial command ALU.
//   - opcode constants OP_ADD..OP_CMP
//   - error status bytes ST_ERR_OP (unknown opcode) and ST_ERR_TO (inter-byte timeout)
//   - state_t: FSM state encoding used by cmd_alu_pro
package cmd_alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h0A;
  localparam logic [7:0] OP_SUB = 8'h0B;
  localparam logic [7:0] OP_AND = 8'h0C;
  localparam logic [7:0] OP_OR  = 8'h0D;
  localparam logic [7:0] OP_XOR = 8'h0E;
  localparam logic [7:0] OP_SHL = 8'h0F;
  localparam logic [7:0] OP_CMP = 8'h10;

  localparam logic [7:0] ST_ERR_OP = 8'h80;
  localparam logic [7:0] ST_ERR_TO = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_SEND  = 3'd4,
    S_HOLD  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

endpackage

// File: rtl/cmd_alu_core.sv
// cmd_alu_core: purely combinational ALU evaluated in the EXEC cycle.
//   a, b      in  DW   operands
//   cmd       in  8    opcode byte
//   r         out DW   result
//   c         out 1    carry (add) / borrow (sub), 0 otherwise
//   z         out 1    result is zero
//   valid_op  out 1    cmd is a known opcode
module cmd_alu_core
  import cmd_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [7:0]    cmd,
  output logic [DW-1:0] r,
  output logic          c,
  output logic          z,
  output logic          valid_op
);

  logic [DW:0] sum;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    r        = '0;
    c        = 1'b0;
    valid_op = 1'b1;
    case (cmd)
      OP_ADD: begin
        r = sum[DW-1:0];
        c = sum[DW];
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      // Only B[4:0] is the shift amount; amounts >= DW shift everything out.
      OP_SHL: r = a << b[4:0];
      OP_CMP: r = DW'(a < b);
      default: valid_op = 1'b0;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/cmd_alu_pro.sv
// cmd_alu_pro: byte-serial command ALU between a UART receiver and transmitter.
// Frame in : CMD, NB bytes of A, NB bytes of B (MSB first).
// Frame out: status byte, then NB result bytes MSB first (status only on error).
//   clk          in   system clock
//   res          in   synchronous active-low reset
//   din_pro      in   received byte, qualified by en_din_pro
//   en_din_pro   in   one-cycle receive strobe
//   dout_pro     out  byte to transmit (holds last value between strobes)
//   en_dout_pro  out  one-cycle transmit strobe
//   tx_busy      in   transmitter busy, rises the cycle after en_dout_pro
//   busy_pro     out  high whenever the FSM is not IDLE
//   drop_pro     out  pulses in the same cycle a receive strobe is discarded
// Handshake: a receive strobe is consumed only in IDLE/GET_A/GET_B; a
// transmit strobe is issued only from SEND while tx_busy is low, and HOLD
// gives the transmitter one cycle to raise tx_busy before it is sampled again.
// FSM state is visible as state_q for checkers.
module cmd_alu_pro
  import cmd_alu_pkg::*;
#(
  parameter int NB     = 1,
  parameter int TO_CYC = 1000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] din_pro,
  input  logic       en_din_pro,
  output logic [7:0] dout_pro,
  output logic       en_dout_pro,
  input  logic       tx_busy,
  output logic       busy_pro,
  output logic       drop_pro
);

  localparam int DW = 8 * NB;
  localparam int OW = DW + 8;
  localparam bit TO_EN = (TO_CYC > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TO_CYC - 1) : 32'd0;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   idle_q, idle_d;
  logic [OW-1:0] out_q, out_d;
  logic [2:0]    rem_q, rem_d;
  logic [7:0]    dout_q, dout_d;

  logic          fire;
  logic          drop;
  logic          timeout;
  logic [DW-1:0] alu_r;
  logic          alu_c, alu_z, alu_ok;

  cmd_alu_core #(.DW(DW)) u_core (
    .a        (a_q),
    .b        (b_q),
    .cmd      (cmd_q),
    .r        (alu_r),
    .c        (alu_c),
    .z        (alu_z),
    .valid_op (alu_ok)
  );

  // Idle counter reaching TO_CYC-1 means this edge completes TO_CYC idle cycles.
  assign timeout = TO_EN && (idle_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    fire    = 1'b0;
    drop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_din_pro) begin
          cmd_d   = din_pro;
          cnt_d   = '0;
          idle_d  = '0;
          state_d = S_GET_A;
        end
      end

      S_GET_A, S_GET_B: begin
        if (en_din_pro) begin
          idle_d = '0;
          if (state_q == S_GET_A) a_d = (a_q << 8) | DW'(din_pro);
          else                    b_d = (b_q << 8) | DW'(din_pro);
          if (cnt_q == 3'(NB - 1)) begin
            cnt_d   = '0;
            state_d = (state_q == S_GET_A) ? S_GET_B : S_EXEC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (timeout) begin
          idle_d  = '0;
          out_d   = {ST_ERR_TO, {DW{1'b0}}};
          rem_d   = 3'd1;
          state_d = S_SEND;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      S_EXEC: begin
        drop = en_din_pro;
        if (alu_ok) begin
          out_d = {6'b0, alu_z, alu_c, alu_r};
          rem_d = 3'(NB + 1);
        end else begin
          out_d = {ST_ERR_OP, {DW{1'b0}}};
          rem_d = 3'd1;
        end
        state_d = S_SEND;
      end

      S_SEND: begin
        drop = en_din_pro;
        if (!tx_busy) begin
          fire    = 1'b1;
          dout_d  = out_q[OW-1 -: 8];
          out_d   = out_q << 8;
          rem_d   = rem_q - 3'd1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        drop    = en_din_pro;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        drop = en_din_pro;
        if (!tx_busy) state_d = (rem_q != 3'd0) ? S_SEND : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
    end
  end

  // Strobes are combinational so the first byte leaves the cycle after EXEC;
  // they are suppressed while reset is asserted so an abandoned frame emits nothing.
  assign en_dout_pro = fire & res;
  assign dout_pro    = en_dout_pro ? out_q[OW-1 -: 8] : dout_q;
  assign drop_pro    = drop & res;
  assign busy_pro    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_alu_pro.sv
module tb_cmd_alu_pro;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic res;

  logic [7:0] din1, din2, dout1, dout2;
  logic       en1, en2, eno1, eno2;
  logic       tx_raw1, tx_raw2, hold1;
  logic       tx_busy1, tx_busy2;
  logic       busy1, busy2, drop1, drop2;

  assign tx_busy1 = tx_raw1 | hold1;
  assign tx_busy2 = tx_raw2;

  cmd_alu_pro #(.NB(1), .TO_CYC(50)) u_dut1 (
    .clk(clk), .res(res), .din_pro(din1), .en_din_pro(en1),
    .dout_pro(dout1), .en_dout_pro(eno1), .tx_busy(tx_busy1),
    .busy_pro(busy1), .drop_pro(drop1)
  );

  cmd_alu_pro #(.NB(2), .TO_CYC(0)) u_dut2 (
    .clk(clk), .res(res), .din_pro(din2), .en_din_pro(en2),
    .dout_pro(dout2), .en_dout_pro(eno2), .tx_busy(tx_busy2),
    .busy_pro(busy2), .drop_pro(drop2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_count1 = 0, en_count2 = 0;
  int en_cyc1 = 0, strobe_cyc1 = 0;
  bit drop_ok1 = 1'b0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transmitter models ----------------
  initial begin
    tx_raw1 = 1'b0;
    forever begin
      @(negedge clk);
      if (eno1) begin
        @(posedge clk); #1 tx_raw1 = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 tx_raw1 = 1'b0;
      end
    end
  end

  initial begin
    tx_raw2 = 1'b0;
    forever begin
      @(negedge clk);
      if (eno2) begin
        @(posedge clk); #1 tx_raw2 = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 tx_raw2 = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (eno1) begin
        en_count1++;
        en_cyc1 = cyc;
        if (exp_q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut1_out: unexpected byte %0h, none expected", dout1);
        end else begin
          e = exp_q1.pop_front();
          check("dut1_out", {24'b0, dout1}, {24'b0, e});
        end
      end
      if (drop1 && !drop_ok1) begin
        tests++; fails++;
        $display("FAIL dut1_drop: got pulse expected none");
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (eno2) begin
        en_count2++;
        if (exp_q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut2_out: unexpected byte %0h, none expected", dout2);
        end else begin
          e = exp_q2.pop_front();
          check("dut2_out", {24'b0, dout2}, {24'b0, e});
        end
      end
      if (drop2) begin
        tests++; fails++;
        $display("FAIL dut2_drop: got pulse expected none");
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_byte(input int d, input logic [7:0] v);
    if (d == 1) exp_q1.push_back(v);
    else        exp_q2.push_back(v);
  endtask

  task automatic push_expect(input int d, input logic [7:0] cmd,
                             input logic [31:0] a, input logic [31:0] b);
    int nb;
    longint unsigned mask, aa, bb, r;
    bit c, ok;
    int sh;
    nb   = (d == 1) ? 1 : 2;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    aa   = a & mask;
    bb   = b & mask;
    r    = 0;
    c    = 1'b0;
    ok   = 1'b1;
    case (cmd)
      8'h0A: begin r = aa + bb; c = (r > mask); end
      8'h0B: begin r = aa - bb; c = (aa < bb); end
      8'h0C: r = aa & bb;
      8'h0D: r = aa | bb;
      8'h0E: r = aa ^ bb;
      8'h0F: begin sh = int'(bb % 32); r = (sh >= 8 * nb) ? 0 : (aa << sh); end
      8'h10: r = (aa < bb) ? 1 : 0;
      default: ok = 1'b0;
    endcase
    r = r & mask;
    if (!ok) push_byte(d, 8'h80);
    else begin
      push_byte(d, {6'b0, (r == 0), c});
      for (int i = nb - 1; i >= 0; i--) push_byte(d, 8'(r >> (8 * i)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int d, input logic [7:0] v, input int maxgap);
    repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    if (d == 1) begin din1 = v; en1 = 1'b1; strobe_cyc1 = cyc; end
    else        begin din2 = v; en2 = 1'b1; end
    @(posedge clk); #1;
    en1 = 1'b0;
    en2 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 3000; i++) begin
      if (d == 1 && !busy1 && exp_q1.size() == 0) return;
      if (d == 2 && !busy2 && exp_q2.size() == 0) return;
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL wait_idle_dut%0d: still busy after 3000 cycles, expected idle", d);
  endtask

  task automatic wait_out1(input int n);
    for (int i = 0; i < 500; i++) begin
      if (en_count1 > n) return;
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL wait_out1: no output strobe in 500 cycles, expected one");
  endtask

  task automatic send_frame(input int d, input logic [7:0] cmd,
                            input logic [31:0] a, input logic [31:0] b, input int maxgap);
    int nb;
    nb = (d == 1) ? 1 : 2;
    wait_idle(d);
    push_expect(d, cmd, a, b);
    send_byte(d, cmd, maxgap);
    for (int i = nb - 1; i >= 0; i--) send_byte(d, 8'(a >> (8 * i)), maxgap);
    for (int i = nb - 1; i >= 0; i--) send_byte(d, 8'(b >> (8 * i)), maxgap);
  endtask

  function automatic logic [7:0] rand_cmd();
    int k;
    k = $urandom_range(0, 7);
    return (k == 7) ? 8'($urandom) : 8'(8'h0A + k);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n, lat;
    logic [7:0] cmd;
    logic [31:0] a, b;
    res = 1'b0; en1 = 1'b0; en2 = 1'b0; din1 = '0; din2 = '0; hold1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout1", {24'b0, dout1}, 32'h0);
    check("rst_en1",   {31'b0, eno1},  32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_drop1", {31'b0, drop1}, 32'h0);
    check("rst_dout2", {24'b0, dout2}, 32'h0);
    check("rst_busy2", {31'b0, busy2}, 32'h0);
    @(posedge clk); #1 res = 1'b1;
    @(posedge clk); #1;

    // add, with latency and pulse count
    n = en_count1;
    send_frame(1, 8'h0A, 32'h05, 32'h03, 0);
    wait_out1(n);
    check("exec_latency", en_cyc1 - strobe_cyc1, 32'd2);
    wait_idle(1);
    check("add_pulses", en_count1 - n, 32'd2);

    send_frame(1, 8'h0B, 32'h03, 32'h05, 2);
    send_frame(1, 8'h0C, 32'hF0, 32'h0F, 2);
    send_frame(1, 8'h0F, 32'h01, 32'h09, 2);
    send_frame(1, 8'h55, 32'hAA, 32'hBB, 1);
    send_frame(1, 8'h01, 32'h02, 32'h03, 1);
    send_frame(2, 8'h0A, 32'hFFFF, 32'h0001, 2);
    send_frame(2, 8'h10, 32'h0001, 32'h0002, 2);
    wait_idle(1);
    wait_idle(2);

    // inter-byte timeout
    push_byte(1, 8'h40);
    n = en_count1;
    send_byte(1, 8'h0A, 0);
    send_byte(1, 8'h01, 0);
    wait_out1(n);
    lat = en_cyc1 - strobe_cyc1;
    check("timeout_not_early", {31'b0, lat >= 50}, 32'd1);
    check("timeout_not_late",  {31'b0, lat <= 52}, 32'd1);
    wait_idle(1);
    @(negedge clk);
    check("timeout_idle", {31'b0, busy1}, 32'h0);
    @(posedge clk); #1;

    // transmitter held busy after EXEC
    hold1 = 1'b1;
    n = en_count1;
    send_frame(1, 8'h0B, 32'h03, 32'h05, 0);
    repeat (200) @(posedge clk);
    #1;
    check("hold_no_output", en_count1 - n, 32'd0);
    check("hold_busy", {31'b0, busy1}, 32'h1);
    hold1 = 1'b0;
    wait_idle(1);
    check("hold_pulses", en_count1 - n, 32'd2);

    // strobe in WAIT is dropped
    n = en_count1;
    send_frame(1, 8'h0C, 32'hF0, 32'h0F, 0);
    wait_out1(n);
    hold1 = 1'b1;
    @(posedge clk); #1;
    din1 = 8'h0A; en1 = 1'b1; drop_ok1 = 1'b1;
    @(negedge clk);
    check("wait_drop", {31'b0, drop1}, 32'h1);
    check("wait_dout_hold", {24'b0, dout1}, 32'h02);
    check("wait_no_strobe", {31'b0, eno1}, 32'h0);
    @(posedge clk); #1;
    en1 = 1'b0; drop_ok1 = 1'b0;
    hold1 = 1'b0;
    wait_idle(1);
    check("wait_pulses", en_count1 - n, 32'd2);

    // randomized traffic on both widths
    for (int i = 0; i < 40; i++) begin
      cmd = rand_cmd();
      a = $urandom;
      b = (cmd == 8'h0F) ? 32'($urandom_range(0, 15)) : $urandom;
      send_frame(1, cmd, a, b, 3);
    end
    for (int i = 0; i < 40; i++) begin
      cmd = rand_cmd();
      a = $urandom;
      b = (cmd == 8'h0F) ? 32'($urandom_range(0, 20)) : $urandom;
      send_frame(2, cmd, a, b, 3);
    end
    wait_idle(1);
    wait_idle(2);

    // reset between status byte and result byte
    n = en_count1;
    send_frame(1, 8'h0A, 32'h05, 32'h03, 0);
    wait_out1(n);
    res = 1'b0;
    @(posedge clk); #1 res = 1'b1;
    @(negedge clk);
    check("rst_mid_en",   {31'b0, eno1},  32'h0);
    check("rst_mid_dout", {24'b0, dout1}, 32'h0);
    check("rst_mid_busy", {31'b0, busy1}, 32'h0);
    check("rst_mid_drop", {31'b0, drop1}, 32'h0);
    exp_q1.delete();
    n = en_count1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_silent", en_count1 - n, 32'd0);

    check("q1_empty", exp_q1.size(), 32'd0);
    check("q2_empty", exp_q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
